// File: rtl/rfphoenix_hpt_walker.sv
// Hashed page table walker: arbitrates data/instruction TLB misses and searches PTGs for an HPTE.
// HPTE layout: [127] v, [126] g, [121:112] asid, [111:82] vpnhi, [81:64] vpn, [63:0] payload.
`timescale 1ns/1ps
module rfphoenix_hpt_walker #(
  parameter logic [31:0] PTG_BASE   = 32'hFFF0_0000,
  parameter int unsigned PTG_LOG2   = 10,
  parameter int unsigned MAX_PROBES = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req0_i,
  input  logic [31:0]  vadr0_i,
  input  logic [9:0]   asid0_i,
  output logic         ack0_o,
  input  logic         req1_i,
  input  logic [31:0]  vadr1_i,
  input  logic [9:0]   asid1_i,
  output logic         ack1_o,
  input  logic         abort_i,
  output logic         mreq_o,
  output logic [31:0]  madr_o,
  input  logic         mack_i,
  input  logic [127:0] mdat_i,
  output logic         done_o,
  output logic         done_id_o,
  output logic         fault_o,
  output logic [127:0] hpte_o
);

  typedef enum logic [2:0] {StIdle, StFetch, StCheck, StDone, StFault} state_e;

  localparam logic [PTG_LOG2-1:0] IdxOne = 1;

  state_e               state_q, state_d;
  logic                 last_q, id_q, abort_q, ack0_q, ack1_q;
  logic [17:0]          vpn_q;
  logic [9:0]           asid_q;
  logic [2:0]           probe_q, beat_q;
  logic [PTG_LOG2-1:0]  idx_q;
  logic [127:0]         ent_q;

  logic                 grant0, grant1, match, last_beat, more_probes;
  logic [17:0]          vpn_sel, hash_full;
  logic [9:0]           asid_sel;
  logic                 unused_bits;

  // Round-robin: on a tie the requester not granted last wins.
  assign grant0    = req0_i & (~req1_i | last_q);
  assign grant1    = req1_i & ~grant0;
  assign vpn_sel   = grant0 ? vadr0_i[31:14] : vadr1_i[31:14];
  assign asid_sel  = grant0 ? asid0_i : asid1_i;
  assign hash_full = vpn_sel ^ {asid_sel, 8'b0};

  assign match = ent_q[127] && (ent_q[111:82] == 30'b0) && (ent_q[81:64] == vpn_q) &&
                 (ent_q[126] || (ent_q[121:112] == asid_q));
  assign last_beat   = (beat_q == 3'd7);
  assign more_probes = (probe_q < 3'(MAX_PROBES - 1));

  assign unused_bits = ^{vadr0_i[13:0], vadr1_i[13:0], hash_full[17:PTG_LOG2]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (grant0 || grant1) state_d = StFetch;
      StFetch: if (mack_i) state_d = (abort_i || abort_q) ? StIdle : StCheck;
      StCheck: begin
        if (abort_i)                       state_d = StIdle;
        else if (match)                    state_d = StDone;
        else if (!last_beat || more_probes) state_d = StFetch;
        else                               state_d = StFault;
      end
      StDone, StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      abort_q <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      vpn_q   <= '0;
      asid_q  <= '0;
      probe_q <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      ent_q   <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (grant0 || grant1) begin
            ack0_q  <= grant0;
            ack1_q  <= grant1;
            id_q    <= grant1;
            last_q  <= grant1;
            vpn_q   <= vpn_sel;
            asid_q  <= asid_sel;
            idx_q   <= hash_full[PTG_LOG2-1:0];
            probe_q <= '0;
            beat_q  <= '0;
          end
        end
        StFetch: begin
          if (mack_i) begin
            ent_q   <= mdat_i;
            abort_q <= 1'b0;
          end else if (abort_i) begin
            abort_q <= 1'b1;
          end
        end
        StCheck: begin
          if (!abort_i && !match) begin
            if (!last_beat) begin
              beat_q <= beat_q + 3'd1;
            end else if (more_probes) begin
              probe_q <= probe_q + 3'd1;
              beat_q  <= '0;
              idx_q   <= idx_q + IdxOne;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack0_o    = ack0_q;
    ack1_o    = ack1_q;
    mreq_o    = (state_q == StFetch);
    madr_o    = '0;
    done_o    = 1'b0;
    fault_o   = 1'b0;
    done_id_o = 1'b0;
    hpte_o    = '0;
    if (state_q == StFetch) madr_o = PTG_BASE + (32'(idx_q) << 7) + (32'(beat_q) << 4);
    if ((state_q == StDone || state_q == StFault) && !abort_i) begin
      done_o    = 1'b1;
      done_id_o = id_q;
      fault_o   = (state_q == StFault);
      if (state_q == StDone) hpte_o = ent_q;
    end
  end

endmodule

// File: tb/tb_rfphoenix_hpt_walker.sv
// Directed bench for rfphoenix_hpt_walker: memory responder plus scoreboards for reads and completions.
`timescale 1ns/1ps
module tb_rfphoenix_hpt_walker;

  localparam logic [31:0] BASE = 32'hFFF0_0000;

  typedef struct packed {
    logic         id;
    logic         fault;
    logic [127:0] hpte;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0, req1, ack0, ack1, abort, mreq, mack;
  logic         done, done_id, fault;
  logic [31:0]  vadr0, vadr1, madr;
  logic [9:0]   asid0, asid1;
  logic [127:0] mdat, hpte;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  int wait_cycles = 0;
  int nreads = 0;

  logic [127:0] mem [logic [31:0]];
  logic [31:0]  adrq[$];
  exp_t         sbq[$];
  int           done_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rfphoenix_hpt_walker dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req0_i    (req0),
    .vadr0_i   (vadr0),
    .asid0_i   (asid0),
    .ack0_o    (ack0),
    .req1_i    (req1),
    .vadr1_i   (vadr1),
    .asid1_i   (asid1),
    .ack1_o    (ack1),
    .abort_i   (abort),
    .mreq_o    (mreq),
    .madr_o    (madr),
    .mack_i    (mack),
    .mdat_i    (mdat),
    .done_o    (done),
    .done_id_o (done_id),
    .fault_o   (fault),
    .hpte_o    (hpte)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] adr(input int idx, input int beat);
    return BASE + 32'((idx % 1024) * 128) + 32'(beat * 16);
  endfunction

  function automatic logic [127:0] mk(input bit v, input bit g, input logic [9:0] as,
                                      input logic [29:0] vh, input logic [17:0] vp,
                                      input logic [63:0] pay);
    logic [127:0] e;
    e = '0;
    e[127] = v;
    e[126] = g;
    e[121:112] = as;
    e[111:82] = vh;
    e[81:64] = vp;
    e[63:0] = pay;
    return e;
  endfunction

  // Memory responder: acks after wait_cycles stall cycles and checks each read address.
  initial begin
    int wcnt;
    wcnt = 0;
    mack = 1'b0;
    mdat = '0;
    forever begin
      @(negedge clk);
      mack = 1'b0;
      if (mreq) begin
        if (wcnt >= wait_cycles) begin
          mack = 1'b1;
          mdat = mem.exists(madr) ? mem[madr] : '0;
          nreads++;
          wcnt = 0;
          if (adrq.size() == 0) chk("extra_read", 32'(adrq.size()), 1);
          else chk("madr", madr, adrq.pop_front());
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Completion monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cyc_q.push_back(cyc);
        if (sbq.size() == 0) begin
          chk("extra_done", 32'(sbq.size()), 1);
        end else begin
          e = sbq.pop_front();
          chk("done_id", done_id, e.id);
          chk("fault", fault, e.fault);
          chk("hpte", hpte, e.hpte);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input bit id, input logic [31:0] va, input logic [9:0] as,
                       output int ack_cyc);
    int t0;
    @(negedge clk);
    t0 = cyc;
    if (id) begin req1 = 1'b1; vadr1 = va; asid1 = as; end
    else    begin req0 = 1'b1; vadr0 = va; asid0 = as; end
    ack_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (id ? ack1 : ack0) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (id) req1 = 1'b0; else req0 = 1'b0;
    chk("ack_latency", 32'(ack_cyc - t0), 1);
  endtask

  task automatic both(input logic [31:0] va0, input logic [9:0] as0,
                      input logic [31:0] va1, input logic [9:0] as1,
                      output int a0, output int a1);
    @(negedge clk);
    req0 = 1'b1; vadr0 = va0; asid0 = as0;
    req1 = 1'b1; vadr1 = va1; asid1 = as1;
    a0 = -1;
    a1 = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack0 && a0 < 0) begin a0 = cyc; req0 = 1'b0; end
      if (ack1 && a1 < 0) begin a1 = cyc; req1 = 1'b0; end
      if (a0 >= 0 && a1 >= 0) break;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("both_acked", 32'(a0 >= 0 && a1 >= 0), 1);
  endtask

  task automatic wait_done(output int dc);
    for (int i = 0; i < 3000; i++) begin
      if (done_cyc_q.size() > 0) break;
      @(negedge clk);
      #1;
    end
    if (done_cyc_q.size() > 0) begin
      dc = done_cyc_q.pop_front();
    end else begin
      chk("done_timeout", 32'(done_cyc_q.size()), 1);
      dc = -1;
    end
  endtask

  initial begin
    logic [127:0] e1, e2, e4;
    int a, d, a0, a1, d0, d1, r0;
    req0 = 1'b0; req1 = 1'b0; abort = 1'b0;
    vadr0 = '0; vadr1 = '0; asid0 = '0; asid1 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_mreq", mreq, 0);
    chk("rst_madr", madr, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_fault", fault, 0);
    chk("rst_hpte", hpte, 0);
    rst_n = 1'b1;

    // Hit at beat 0 of PTG 263, zero-wait bus
    e1 = mk(1, 0, 10'd5, 30'd0, 18'd7, 64'hA1A1_0000_1111_2222);
    mem[adr(263, 0)] = e1;
    wait_cycles = 0;
    adrq.push_back(adr(263, 0));
    sbq.push_back('{id: 1'b0, fault: 1'b0, hpte: e1});
    issue(0, 32'h0001_C000, 10'd5, a);
    wait_done(d);
    chk("t1_done_lat", 32'(d - a), 2);

    // Hit at beat 5 of probe 2, W = 2; a vpnhi != 0 entry is skipped on the way
    mem[adr(832, 2)] = mk(1, 1, 10'd3, 30'd1, 18'd64, 64'hBAD);
    e2 = mk(1, 0, 10'd3, 30'd0, 18'd64, 64'hB2B2_3333_4444_5555);
    mem[adr(834, 5)] = e2;
    wait_cycles = 2;
    for (int p = 0; p < 3; p++)
      for (int b = 0; b < 8; b++)
        if (p < 2 || b <= 5) adrq.push_back(adr(832 + p, b));
    sbq.push_back('{id: 1'b1, fault: 1'b0, hpte: e2});
    issue(1, 32'h0010_0000, 10'd3, a);
    wait_done(d);
    chk("t2_done_lat", 32'(d - a), 22 * 4);

    // No match: 4 probes wrap from PTG 1023 to 0; a v=0 entry there is ignored
    wait_cycles = 0;
    mem[adr(0, 3)] = mk(0, 1, 10'd0, 30'd0, 18'd1023, 64'hC3);
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 8; b++) adrq.push_back(adr(1023 + p, b));
    r0 = nreads;
    sbq.push_back('{id: 1'b0, fault: 1'b1, hpte: 128'h0});
    issue(0, 32'h00FF_C000, 10'd0, a);
    wait_done(d);
    chk("t3_reads", 32'(nreads - r0), 32);
    chk("t3_done_lat", 32'(d - a), 64);

    // Wrong asid with g=0 skipped, g=1 entry at beat 1 matched
    e4 = mk(1, 1, 10'd5, 30'd0, 18'd7, 64'hD4D4_6666_7777_8888);
    mem[adr(263, 1)] = e4;
    adrq.push_back(adr(263, 0));
    adrq.push_back(adr(263, 1));
    sbq.push_back('{id: 1'b1, fault: 1'b0, hpte: e4});
    issue(1, 32'h0001_C000, 10'd9, a);
    wait_done(d);
    chk("t4_done_lat", 32'(d - a), 4);

    // Arbitration from reset: req0 first, req1 granted from the IDLE cycle after done
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    adrq.push_back(adr(263, 0));
    adrq.push_back(adr(263, 0));
    adrq.push_back(adr(263, 1));
    sbq.push_back('{id: 1'b0, fault: 1'b0, hpte: e1});
    sbq.push_back('{id: 1'b1, fault: 1'b0, hpte: e4});
    both(32'h0001_C000, 10'd5, 32'h0001_C000, 10'd9, a0, a1);
    wait_done(d0);
    wait_done(d1);
    chk("arb_req0_first", 32'(a0 < a1), 1);
    chk("arb_req1_ack", 32'(a1 - d0), 2);

    // After a req0 grant, a tie goes to req1
    adrq.push_back(adr(263, 0));
    sbq.push_back('{id: 1'b0, fault: 1'b0, hpte: e1});
    issue(0, 32'h0001_C000, 10'd5, a);
    wait_done(d);
    adrq.push_back(adr(263, 0));
    adrq.push_back(adr(263, 1));
    adrq.push_back(adr(263, 0));
    sbq.push_back('{id: 1'b1, fault: 1'b0, hpte: e4});
    sbq.push_back('{id: 1'b0, fault: 1'b0, hpte: e1});
    both(32'h0001_C000, 10'd5, 32'h0001_C000, 10'd9, a0, a1);
    wait_done(d0);
    wait_done(d1);
    chk("alt_req1_first", 32'(a1 < a0), 1);
    chk("alt_req0_ack", 32'(a0 - d0), 2);

    // Abort during a 3-cycle wait: read completes, no done, pending req1 served next
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wait_cycles = 3;
    adrq.push_back(adr(263, 0));
    adrq.push_back(adr(263, 0));
    adrq.push_back(adr(263, 1));
    sbq.push_back('{id: 1'b1, fault: 1'b0, hpte: e4});
    req0 = 1'b1; vadr0 = 32'h0001_C000; asid0 = 10'd5;
    req1 = 1'b1; vadr1 = 32'h0001_C000; asid1 = 10'd9;
    a0 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack0) begin a0 = cyc; break; end
    end
    req0 = 1'b0;
    chk("abort_ack0_seen", 32'(a0 >= 0), 1);
    chk("abort_mreq0", mreq, 1);
    @(negedge clk); abort = 1'b1;
    chk("abort_mreq1", mreq, 1);
    @(negedge clk); abort = 1'b0;
    chk("abort_mreq2", mreq, 1);
    @(negedge clk);
    chk("abort_mreq3", mreq, 1);
    a1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack1) begin a1 = cyc; break; end
    end
    req1 = 1'b0;
    chk("abort_req1_ack", 32'(a1 - a0), 5);
    wait_done(d);

    // Reset mid-FETCH drops mreq asynchronously
    issue(0, 32'h0001_C000, 10'd5, a);
    @(negedge clk);
    chk("midrst_mreq_before", mreq, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_mreq", mreq, 0);
    chk("midrst_madr", madr, 0);
    @(negedge clk); rst_n = 1'b1;

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 0);
    chk("adrq_empty", 32'(adrq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
